rnn_host: RTL
=============

Name: rnn_host

Overview:
Bus master that drives the rnn accelerator's 3-bit-address register slave port. It fetches a character sequence's embedding vectors from a local embedding RAM and writes them element-by-element into the accelerator, one character at a time. After each character it starts the recurrent step and polls for completion. After the last character it triggers the dense layer, polls for VALID, and reads the result, which clears the accelerator's hidden state. The result is presented on a valid/ready port, so software issues one start instead of ~4N+N+3 register accesses.

Parameters:
EMB_LEN, 4, elements per embedding vector (accelerator embedding length)
ADDR_W, 10, embedding RAM address width
LEN_W, 8, sequence length width
POLL_MAX, 1023, maximum consecutive poll reads before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
seq_start  in  1  pulse; begin a sequence (accepted only in IDLE)
seq_len  in  LEN_W  number of characters, sampled with seq_start
busy  out  1  high in every state except IDLE and ERROR
err  out  1  poll timeout occurred; sticky until next accepted seq_start
emb_rd  out  1  embedding RAM read strobe
emb_addr  out  ADDR_W  char_idx*EMB_LEN + elem, wraps modulo 2^ADDR_W
emb_rdata  in  16  signed Q8.8 element, valid exactly 1 cycle after emb_rd
av_addr  out  3  slave address
av_write  out  1  slave write strobe, single cycle
av_read  out  1  slave read strobe
av_wdata  out  32  {8'h00, elem index[7:0], data[15:0]}
av_rdata  in  32  slave read data, combinational, same cycle as av_read
res_valid  out  1  result available
res_ready  in  1  result accepted when res_valid&&res_ready
res_data  out  16  signed dense output
res_class  out  1  ~res_data[15] (result >= 0)

Behaviour:
- Reset: all outputs 0; state SYNC_CHK; counters 0. err clears only on reset or an accepted seq_start.
- At most one of av_read/av_write high per cycle. av_addr and av_wdata are 0 when both are low.
- SYNC_CHK: read addr 0. If av_rdata[0]=1, go to SYNC_CLR. Else go to SYNC_LD.
- SYNC_CLR: read addr 7, discard data, go to SYNC_LD. This drains a sequence left VALID by a host reset.
- SYNC_LD: read addr 1 every cycle until av_rdata[0]=1, then go to IDLE.
- IDLE: on seq_start, latch seq_len, set char_idx=0, elem=0, clear err. If seq_len==0 go to DENSE_CMD, else go to FETCH. seq_start in any other state is ignored.
- FETCH: emb_rd=1 at the current address, then go to WR_EMB.
- WR_EMB: write addr 1 with {8'h00, elem, emb_rdata}. If elem==EMB_LEN-1, set elem=0 and go to KICK. Else increment elem and go to FETCH.
- KICK: write addr 0 (any data), then go to POLL_LD.
- POLL_LD: read addr 1 each cycle until av_rdata[0]=1. The first poll falls in the slave's START cycle, so it cannot pass falsely.
  - On exit, increment char_idx.
  - If char_idx+1==seq_len, go to DENSE_CMD. Else go to FETCH.
- DENSE_CMD: write addr 7, then go to POLL_VAL.
- POLL_VAL: read addr 0 until av_rdata[0]=1, then go to RD_RES.
- RD_RES: read addr 7. Capture res_data=av_rdata[15:0] and res_class. Go to OUT.
- OUT: res_valid=1. Hold res_data and res_class stable until res_ready, then go to IDLE. res_valid falls the cycle after the handshake.
- Poll timeout:
  - A poll counter resets on entry to each poll state (SYNC_LD, POLL_LD, POLL_VAL) and increments per poll read.
  - When it reaches POLL_MAX without success, go to ERROR and set err=1.
  - ERROR: accept seq_start (clears err), then go to SYNC_CHK, not FETCH.
- Typical timing: each character costs 2*EMB_LEN+1 cycles plus the slave's compute time. One poll is issued per cycle, with no gaps.

Decomposition:
- Shared package rnn_pkg: the slave address constants (ADDR_START=0, ADDR_INPUT=1, ADDR_RNN_W=2, ADDR_RNN_U=3, ADDR_RNN_B=4, ADDR_DENSE=5, ADDR_DENSE_B=6, ADDR_RESULT=7), EMB_LEN/RNN_LEN, and the host state enum.
- One natural sub-module: rnn_poll_ctr, a poll counter with clear/inc/timeout flag.

Test Plan:
- Reset with slave model idle in LOAD → 1 read addr 0, then read addr 1 returns 1 → IDLE at cycle 3; busy=0, all strobes 0.
- seq_len=2, RAM[0..7]=0x0100,0x0080,0xFF00,0,1,2,3,4; slave LOAD returns after 40 cycles:
  - writes appear on addr 1 with wdata 0x00000100, 0x00010080, 0x0002FF00, 0x00030000, then a write to addr 0;
  - second character uses emb_addr 4..7;
  - then a write to addr 7, polls of addr 0, a read of addr 7 returning 0xFFFFFF80 → res_data=0xFF80, res_class=0.
- seq_len=0 → first bus op is a write to addr 7; no emb_rd is ever asserted.
- res_ready held low 20 cycles → res_valid and res_data stable; seq_start pulses during this time are ignored; IDLE the cycle after res_ready.
- Slave never reports LOAD in POLL_LD → exactly POLL_MAX reads, then err=1, busy=0. A following seq_start clears err and re-enters SYNC_CHK.
- Host rst asserted while slave in VALID → after release: read addr 0 =1, read addr 7 (slave clears), then SYNC_LD → IDLE.

Source files
------------

// File: rtl/rnn_pkg.sv
// Shared definitions for the rnn accelerator host: slave register map,
// accelerator dimensions and host sequencer state encoding.
package rnn_pkg;

    localparam logic [2:0] ADDR_START   = 3'd0;
    localparam logic [2:0] ADDR_INPUT   = 3'd1;
    localparam logic [2:0] ADDR_RNN_W   = 3'd2;
    localparam logic [2:0] ADDR_RNN_U   = 3'd3;
    localparam logic [2:0] ADDR_RNN_B   = 3'd4;
    localparam logic [2:0] ADDR_DENSE   = 3'd5;
    localparam logic [2:0] ADDR_DENSE_B = 3'd6;
    localparam logic [2:0] ADDR_RESULT  = 3'd7;

    localparam int EMB_LEN = 4;
    localparam int RNN_LEN = 4;

    localparam logic [3:0] ST_SYNC_CHK  = 4'd0;
    localparam logic [3:0] ST_SYNC_CLR  = 4'd1;
    localparam logic [3:0] ST_SYNC_LD   = 4'd2;
    localparam logic [3:0] ST_IDLE      = 4'd3;
    localparam logic [3:0] ST_FETCH     = 4'd4;
    localparam logic [3:0] ST_WR_EMB    = 4'd5;
    localparam logic [3:0] ST_KICK      = 4'd6;
    localparam logic [3:0] ST_POLL_LD   = 4'd7;
    localparam logic [3:0] ST_DENSE_CMD = 4'd8;
    localparam logic [3:0] ST_POLL_VAL  = 4'd9;
    localparam logic [3:0] ST_RD_RES    = 4'd10;
    localparam logic [3:0] ST_OUT       = 4'd11;
    localparam logic [3:0] ST_ERROR     = 4'd12;

    // States that issue one status poll read per cycle and share the timeout.
    function automatic logic is_poll_state(input logic [3:0] s);
        return (s == ST_SYNC_LD) || (s == ST_POLL_LD) || (s == ST_POLL_VAL);
    endfunction

endpackage

// File: rtl/rnn_poll_ctr.sv
// Poll counter: counts consecutive poll reads and flags the last allowed one.
module rnn_poll_ctr #(
    parameter int POLL_MAX = 1023,
    parameter int CNT_W    = $clog2(POLL_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // High while the current poll read is the POLL_MAX-th one since entry.
    assign last = (cnt_q == CNT_W'(POLL_MAX - 1));

    // Clear wins over increment; saturate so the flag cannot wrap away.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rnn_host.sv
// rnn_host: streams embedding vectors into the rnn accelerator, runs each
// recurrent step, triggers the dense layer and returns the result on a
// valid/ready port.
module rnn_host #(
    parameter int EMB_LEN  = rnn_pkg::EMB_LEN,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 8,
    parameter int POLL_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seq_start,
    input  logic [LEN_W-1:0]  seq_len,
    output logic              busy,
    output logic              err,
    output logic              emb_rd,
    output logic [ADDR_W-1:0] emb_addr,
    input  logic [15:0]       emb_rdata,
    output logic [2:0]        av_addr,
    output logic              av_write,
    output logic              av_read,
    output logic [31:0]       av_wdata,
    input  logic [31:0]       av_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic              res_class
);
    import rnn_pkg::*;

    logic [3:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] char_q, char_d;
    logic [7:0]       elem_q, elem_d;
    logic             err_q, err_d;
    logic [15:0]      res_data_q, res_data_d;
    logic             res_class_q, res_class_d;

    logic             bus_rd, bus_wr;
    logic [2:0]       bus_addr;
    logic [31:0]      bus_wdata;
    logic             poll_last;
    logic             out_en;
    logic             rdata_unused;

    assign rdata_unused = ^av_rdata[31:16];

    rnn_poll_ctr #(
        .POLL_MAX (POLL_MAX)
    ) u_poll_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (!is_poll_state(state_q)),
        .inc   (is_poll_state(state_q)),
        .last  (poll_last)
    );

    // Sequencer: next state, counters and the single bus operation of this cycle.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        char_d      = char_q;
        elem_d      = elem_q;
        err_d       = err_q;
        res_data_d  = res_data_q;
        res_class_d = res_class_q;
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        bus_addr    = 3'd0;
        bus_wdata   = 32'd0;
        case (state_q)
            ST_SYNC_CHK: begin
                bus_rd   = 1'b1;
                bus_addr = ADDR_START;
                state_d  = av_rdata[0] ? ST_SYNC_CLR : ST_SYNC_LD;
            end
            ST_SYNC_CLR: begin
                bus_rd   = 1'b1;
                bus_addr = ADDR_RESULT;
                state_d  = ST_SYNC_LD;
            end
            ST_SYNC_LD: begin
                bus_rd   = 1'b1;
                bus_addr = ADDR_INPUT;
                if (av_rdata[0]) begin
                    state_d = ST_IDLE;
                end else if (poll_last) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_IDLE: begin
                if (seq_start) begin
                    len_d   = seq_len;
                    char_d  = '0;
                    elem_d  = '0;
                    err_d   = 1'b0;
                    state_d = (seq_len == '0) ? ST_DENSE_CMD : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WR_EMB;
            end
            ST_WR_EMB: begin
                bus_wr    = 1'b1;
                bus_addr  = ADDR_INPUT;
                bus_wdata = {8'h00, elem_q, emb_rdata};
                if (elem_q == 8'(EMB_LEN - 1)) begin
                    elem_d  = '0;
                    state_d = ST_KICK;
                end else begin
                    elem_d  = elem_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_KICK: begin
                bus_wr   = 1'b1;
                bus_addr = ADDR_START;
                state_d  = ST_POLL_LD;
            end
            ST_POLL_LD: begin
                bus_rd   = 1'b1;
                bus_addr = ADDR_INPUT;
                if (av_rdata[0]) begin
                    char_d  = char_q + 1'b1;
                    state_d = (char_d == len_q) ? ST_DENSE_CMD : ST_FETCH;
                end else if (poll_last) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_DENSE_CMD: begin
                bus_wr   = 1'b1;
                bus_addr = ADDR_RESULT;
                state_d  = ST_POLL_VAL;
            end
            ST_POLL_VAL: begin
                bus_rd   = 1'b1;
                bus_addr = ADDR_START;
                if (av_rdata[0]) begin
                    state_d = ST_RD_RES;
                end else if (poll_last) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_RD_RES: begin
                bus_rd      = 1'b1;
                bus_addr    = ADDR_RESULT;
                res_data_d  = av_rdata[15:0];
                res_class_d = ~av_rdata[15];
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (seq_start) begin
                    err_d   = 1'b0;
                    state_d = ST_SYNC_CHK;
                end
            end
            default: begin
                state_d = ST_SYNC_CHK;
            end
        endcase
    end

    // State and datapath registers; reset lands in the slave resync check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC_CHK;
            len_q       <= '0;
            char_q      <= '0;
            elem_q      <= '0;
            err_q       <= 1'b0;
            res_data_q  <= '0;
            res_class_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            char_q      <= char_d;
            elem_q      <= elem_d;
            err_q       <= err_d;
            res_data_q  <= res_data_d;
            res_class_q <= res_class_d;
        end
    end

    // The reset state already issues a read, so strobes are held off while rst is high.
    assign out_en    = ~rst;
    assign av_read   = bus_rd & out_en;
    assign av_write  = bus_wr & out_en;
    assign av_addr   = {3{out_en}} & bus_addr;
    assign av_wdata  = {32{out_en}} & bus_wdata;
    assign emb_rd    = (state_q == ST_FETCH) & out_en;
    assign emb_addr  = ADDR_W'(int'(char_q) * EMB_LEN + int'(elem_q));
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_ERROR) && out_en;
    assign err       = err_q;
    assign res_valid = (state_q == ST_OUT) & out_en;
    assign res_data  = res_data_q;
    assign res_class = res_class_q;

endmodule
